mod29_stim_collector: RTL

- Drives the mod29 input interface (pib30, piv31_2) with a sequenced stimulus stream.
- Collects the mod29 outputs (pob32, pov33_2, pob34) into a 16-bit MISR signature.
- Acts as the source/sink end of mod29's port set, for on-chip self-test and bring-up.
- Runs one start/done transaction per test pass.

---
 rtl/mod29_stim_collector.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mod29_stim_collector.sv
// mod29_stim_collector: stimulus source and response sink for mod29.
// Each pass drives NUM_VECTORS stimulus words onto mod29's inputs (pib30,
// piv31_2). A word is either a counting value or an LFSR value. The bench
// folds each 5-bit response (pob32, pov33_2, pob34) into a 16-bit MISR.
//
// Handshake: start is a level that is sampled only in IDLE. busy is high
// for exactly NUM_VECTORS*(RESP_LAT+1) cycles. done is a one-cycle pulse
// in the FIN state. sig_valid then qualifies signature until the next
// start, abort or reset.
module mod29_stim_collector #(
    parameter int          NUM_VECTORS = 16,
    parameter int          RESP_LAT    = 0,
    parameter logic [3:0]  SEED        = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    output logic        pib30,
    output logic [2:0]  piv31_2,
    input  logic        pob32,
    input  logic [2:0]  pov33_2,
    input  logic        pob34,
    output logic        busy,
    output logic        done,
    output logic        sig_valid,
    output logic [15:0] signature,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_RUN     = 2'd1;
    localparam logic [1:0]  S_FIN     = 2'd2;

    // An all-zero LFSR seed would lock up, so a zero seed is promoted to 1.
    localparam logic [3:0]  SEED_EFF  = (SEED == 4'h0) ? 4'h1 : SEED;
    localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  HOLD_INIT = 4'(RESP_LAT);

    logic [1:0]  state;
    logic [3:0]  stim;
    logic [15:0] misr;
    logic [15:0] vec_cnt;
    logic [3:0]  hold_cnt;
    logic        mode_q;

    logic [4:0]  resp;
    logic        fb;
    logic [15:0] misr_next;
    logic [3:0]  stim_next;

    // Compute the next MISR value and the next stimulus word.
    always_comb begin
        resp      = {pob32, pov33_2, pob34};
        fb        = misr[15] ^ misr[14] ^ misr[12] ^ misr[3];
        misr_next = {misr[14:0], fb} ^ {11'b0, resp};
        stim_next = mode_q ? {stim[2:0], stim[3] ^ stim[2]} : stim + 4'd1;
    end

    // Pass sequencer: hold each vector, capture responses, count vectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            stim      <= 4'h0;
            misr      <= 16'h0000;
            vec_cnt   <= 16'h0000;
            hold_cnt  <= 4'h0;
            mode_q    <= 1'b0;
            sig_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        misr      <= 16'h0000;
                        sig_valid <= 1'b0;
                        vec_cnt   <= 16'h0000;
                        hold_cnt  <= HOLD_INIT;
                        mode_q    <= mode;
                        stim      <= mode ? SEED_EFF : 4'h0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // An aborted pass leaves no partial signature behind.
                        state     <= S_IDLE;
                        stim      <= 4'h0;
                        misr      <= 16'h0000;
                        vec_cnt   <= 16'h0000;
                        hold_cnt  <= 4'h0;
                        sig_valid <= 1'b0;
                    end else if (hold_cnt == 4'h0) begin
                        misr <= misr_next;
                        if (vec_cnt == LAST_VEC) begin
                            state     <= S_FIN;
                            stim      <= 4'h0;
                            sig_valid <= 1'b1;
                        end else begin
                            vec_cnt  <= vec_cnt + 16'd1;
                            stim     <= stim_next;
                            hold_cnt <= HOLD_INIT;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    stim  <= 4'h0;
                end
            endcase
        end
    end

    // Drive the status and pin outputs from the registered state.
    always_comb begin
        busy      = (state == S_RUN);
        done      = (state == S_FIN);
        signature = misr;
        pib30     = stim[3];
        piv31_2   = stim[2:0];
        dbg_state = state;
    end

endmodule
